inst_ram_loader: RTL and testbench

//  Writer side of the instruction-fetch path. Receives a byte stream (16-bit length header,

---
 rtl/inst_ram_loader.sv | 149 ++++++++++++++
 tb/tb_inst_ram_loader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_ram_loader.sv
`timescale 1ns/1ps
// Instruction RAM loader: unpacks a length-prefixed byte stream into
// big-endian 32-bit words and writes them, holding the core until done.
module inst_ram_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [15:0] MAX_WORDS = 16'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  output logic        byte_ready_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  output logic        cpu_hold_o,
  output logic        done_o,
  output logic        err_o,
  output logic [15:0] words_loaded_o
);

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    WRITE,
    DONE,
    ERROR
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [15:0] len_q;
  logic [15:0] idx_q;
  logic [15:0] wl_q;
  logic [1:0]  cnt_q;
  logic [23:0] shift_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;

  logic        xfer;
  logic        restart;
  logic [15:0] len_full;
  logic [15:0] idx_inc;

  assign byte_ready_o = (state_q == LEN_HI) ||
                        (state_q == LEN_LO) ||
                        (state_q == DATA);
  assign xfer     = byte_valid_i & byte_ready_o;
  assign restart  = start_i & ((state_q == IDLE) ||
                               (state_q == DONE) ||
                               (state_q == ERROR));
  assign len_full = {len_q[15:8], byte_i};
  assign idx_inc  = idx_q + 16'd1;

  assign mem_we_o       = we_q;
  assign mem_addr_o     = addr_q;
  assign mem_data_o     = data_q;
  assign done_o         = (state_q == DONE);
  assign err_o          = (state_q == ERROR);
  assign cpu_hold_o     = (state_q != DONE);
  assign words_loaded_o = wl_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) state_d = LEN_HI;
      end
      LEN_HI: begin
        if (xfer) state_d = LEN_LO;
      end
      LEN_LO: begin
        if (xfer) begin
          if (len_full == 16'd0)
            state_d = DONE;
          else if (len_full > MAX_WORDS)
            state_d = ERROR;
          else
            state_d = DATA;
        end
      end
      DATA: begin
        if (xfer && cnt_q == 2'd3) state_d = WRITE;
      end
      WRITE: begin
        if (idx_inc == len_q)
          state_d = DONE;
        else
          state_d = DATA;
      end
      DONE, ERROR: begin
        if (start_i) state_d = LEN_HI;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q   <= 16'd0;
      idx_q   <= 16'd0;
      wl_q    <= 16'd0;
      cnt_q   <= 2'd0;
      shift_q <= 24'd0;
      we_q    <= 1'b0;
      addr_q  <= BASE_ADDR;
      data_q  <= 32'd0;
    end else begin
      // WRITE lasts one cycle, so the strobe tracks entry into it
      we_q <= (state_d == WRITE);
      if (restart) begin
        idx_q <= 16'd0;
        cnt_q <= 2'd0;
        wl_q  <= 16'd0;
      end
      if (state_q == LEN_HI && xfer) begin
        len_q[15:8] <= byte_i;
      end
      if (state_q == LEN_LO && xfer) begin
        len_q[7:0] <= byte_i;
      end
      if (state_q == DATA && xfer) begin
        cnt_q   <= cnt_q + 2'd1;
        shift_q <= {shift_q[15:0], byte_i};
        if (cnt_q == 2'd3) begin
          data_q <= {shift_q, byte_i};
          addr_q <= BASE_ADDR + {14'd0, idx_q, 2'b00};
        end
      end
      if (state_q == WRITE) begin
        idx_q <= idx_inc;
        wl_q  <= wl_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_inst_ram_loader.sv
`timescale 1ns/1ps
// Bench for inst_ram_loader: scoreboard of expected RAM writes,
// checked by a negedge monitor whenever the write strobe fires.
module tb_inst_ram_loader;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [15:0] MAXW = 16'd4;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic [7:0]  byte_i;
  logic        byte_valid_i;
  logic        byte_ready_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic        cpu_hold_o;
  logic        done_o;
  logic        err_o;
  logic [15:0] words_loaded_o;

  inst_ram_loader #(
    .BASE_ADDR(BASE),
    .MAX_WORDS(MAXW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start_i(start_i),
    .byte_i(byte_i),
    .byte_valid_i(byte_valid_i),
    .byte_ready_o(byte_ready_o),
    .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o),
    .cpu_hold_o(cpu_hold_o),
    .done_o(done_o),
    .err_o(err_o),
    .words_loaded_o(words_loaded_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int writes = 0;
  logic [63:0] sb[$];
  logic [63:0] exp_wr;

  task automatic check(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && mem_we_o) begin
      writes++;
      check("we_rdy", 32'(byte_ready_o), 0);
      check("sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        exp_wr = sb.pop_front();
        check("wr_addr", mem_addr_o, exp_wr[63:32]);
        check("wr_data", mem_data_o, exp_wr[31:0]);
      end
    end
  end

  task automatic send(input logic [7:0] b, input bit gaps);
    int n;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        byte_valid_i = 1'b0;
        byte_i = 8'($urandom);
        @(negedge clk);
      end
    end
    byte_i = b;
    byte_valid_i = 1'b1;
    n = 0;
    while (!byte_ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("rdy_timeout", n, 0);
    @(negedge clk);
    byte_valid_i = 1'b0;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic header(input logic [15:0] len, input bit gaps);
    send(len[15:8], gaps);
    send(len[7:0], gaps);
  endtask

  task automatic words(input int n, input bit gaps);
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      sb.push_back({BASE + 32'(i * 4), w});
      send(w[31:24], gaps);
      send(w[23:16], gaps);
      send(w[15:8], gaps);
      send(w[7:0], gaps);
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", 32'(n < 40), 1);
  endtask

  logic [7:0] t1[12];
  int w0;

  initial begin
    t1 = '{8'h00, 8'h02, 8'h24, 8'h01, 8'h00, 8'h05,
           8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    rst = 1'b0;
    start_i = 1'b0;
    byte_i = 8'h00;
    byte_valid_i = 1'b0;
    #12;
    check("rst_ready", 32'(byte_ready_o), 0);
    check("rst_we", 32'(mem_we_o), 0);
    check("rst_addr", mem_addr_o, BASE);
    check("rst_data", mem_data_o, 0);
    check("rst_hold", 32'(cpu_hold_o), 1);
    check("rst_done", 32'(done_o), 0);
    check("rst_err", 32'(err_o), 0);
    check("rst_wl", 32'(words_loaded_o), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("idle_ready", 32'(byte_ready_o), 0);

    // basic two-word image
    pulse_start();
    sb.push_back({BASE, 32'h2401_0005});
    sb.push_back({BASE + 32'd4, 32'h0000_0000});
    for (int i = 0; i < 10; i++) send(t1[i], 1'b0);
    wait_done();
    check("t1_done", 32'(done_o), 1);
    check("t1_hold", 32'(cpu_hold_o), 0);
    check("t1_wl", 32'(words_loaded_o), 2);
    check("t1_sb", 32'(sb.size()), 0);

    // zero-length image
    pulse_start();
    check("t2_hold", 32'(cpu_hold_o), 1);
    check("t2_ndone", 32'(done_o), 0);
    w0 = writes;
    header(16'd0, 1'b0);
    check("t2_done", 32'(done_o), 1);
    check("t2_hold_lo", 32'(cpu_hold_o), 0);
    check("t2_wl", 32'(words_loaded_o), 0);
    repeat (3) @(negedge clk);
    check("t2_nowr", writes, w0);

    // oversize header
    pulse_start();
    header(16'd5, 1'b0);
    check("t3_err", 32'(err_o), 1);
    check("t3_hold", 32'(cpu_hold_o), 1);
    check("t3_ready", 32'(byte_ready_o), 0);
    check("t3_done", 32'(done_o), 0);
    repeat (3) @(negedge clk);
    check("t3_nowr", writes, w0);
    pulse_start();
    check("t3_clr", 32'(err_o), 0);
    check("t3_lenhi", 32'(byte_ready_o), 1);

    // gapped stream
    header(16'd3, 1'b1);
    words(3, 1'b1);
    wait_done();
    check("t4_wl", 32'(words_loaded_o), 3);
    check("t4_sb", 32'(sb.size()), 0);

    // reset mid-load
    pulse_start();
    header(16'd3, 1'b0);
    words(2, 1'b0);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("t5_ready", 32'(byte_ready_o), 0);
    check("t5_we", 32'(mem_we_o), 0);
    check("t5_addr", mem_addr_o, BASE);
    check("t5_data", mem_data_o, 0);
    check("t5_hold", 32'(cpu_hold_o), 1);
    check("t5_done", 32'(done_o), 0);
    check("t5_wl", 32'(words_loaded_o), 0);
    w0 = writes;
    byte_valid_i = 1'b1;
    byte_i = 8'h33;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    byte_valid_i = 1'b0;
    check("t5_nowr", writes, w0);
    check("t5_idle", 32'(byte_ready_o), 0);
    check("t5_sb", 32'(sb.size()), 0);

    // reload from DONE
    pulse_start();
    header(16'd0, 1'b0);
    check("t6_done0", 32'(done_o), 1);
    pulse_start();
    check("t6_hold", 32'(cpu_hold_o), 1);
    check("t6_ndone", 32'(done_o), 0);
    sb.push_back({BASE, 32'hAABB_CCDD});
    header(16'd1, 1'b0);
    check("t6_hold_ld", 32'(cpu_hold_o), 1);
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    send(8'hCC, 1'b0);
    send(8'hDD, 1'b0);
    wait_done();
    check("t6_wl", 32'(words_loaded_o), 1);
    check("t6_sb", 32'(sb.size()), 0);
    check("t6_addr_hold", mem_addr_o, BASE);
    check("t6_data_hold", mem_data_o, 32'hAABB_CCDD);

    // length equal to the limit is accepted
    pulse_start();
    header(MAXW, 1'b1);
    check("t7_noerr", 32'(err_o), 0);
    words(4, 1'b1);
    wait_done();
    check("t7_wl", 32'(words_loaded_o), 4);
    check("t7_sb", 32'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
